// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the sequential execute-stage ALU:
//                operation codes, condition-code bit positions, the CC
//                reset value and the controller state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // Operation codes carried on ALUfun. Codes 9..15 are undefined:
   // they produce 0 and set flags like a logic op.
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SHL = 4'd5;
   localparam logic [3:0] ALU_SHR = 4'd6;
   localparam logic [3:0] ALU_SAR = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;

   // Condition-code bit positions within CC = {CF,OF,SF,ZF}.
   localparam int CC_ZF = 0;
   localparam int CC_SF = 1;
   localparam int CC_OF = 2;
   localparam int CC_CF = 3;

   // CC after reset: ZF set, everything else clear.
   localparam logic [3:0] CC_RESET = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_iter
//  Description : Iterative unsigned shift-add multiplier. One multiplier bit
//                per cycle, LSB first, full 2*BIT_WISE product.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                start         - load operands and begin (ignored while busy)
//                a, b          - multiplier / multiplicand
//                done          - high in the cycle of the final iteration
//                product       - full product, valid while done is high
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
   parameter int BIT_WISE = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [BIT_WISE-1:0]     a,
   input  logic [BIT_WISE-1:0]     b,
   output logic                    done,
   output logic [2*BIT_WISE-1:0]   product
);

   localparam int SHW = $clog2(BIT_WISE);
   localparam logic [SHW-1:0] LAST = SHW'(BIT_WISE - 1);

   logic                  busy;
   logic [SHW-1:0]        cnt;
   logic [2*BIT_WISE-1:0] acc;
   logic [2*BIT_WISE-1:0] mcand;
   logic [BIT_WISE-1:0]   mplier;
   logic [2*BIT_WISE-1:0] acc_next;

   // The product is taken from the next-accumulator value so the caller can
   // capture the result on the same edge that completes the last iteration.
   always_comb begin
      acc_next = acc + (mplier[0] ? mcand : '0);
   end

   assign done    = busy && (cnt == LAST);
   assign product = acc_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start && !busy) begin
         busy   <= 1'b1;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= {{BIT_WISE{1'b0}}, b};
         mplier <= a;
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + SHW'(1);
         if (cnt == LAST) begin
            busy <= 1'b0;
         end
      end
   end

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked execute-stage ALU with registered result and
//                condition codes. Operand order is B op A. Single-cycle ops
//                complete one cycle after accept; MUL is iterative.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid / in_ready - operation handshake
//                ALUfun, set_cc      - op code, update-CC request
//                ALUA, ALUB          - operands
//                out_valid/out_ready - result handshake
//                valE                - registered result
//                CC                  - registered {CF,OF,SF,ZF}
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
   import alu_pkg::*;
#(
   parameter int BIT_WISE = 64,
   parameter int SHW      = $clog2(BIT_WISE)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          ALUfun,
   input  logic                set_cc,
   input  logic [BIT_WISE-1:0] ALUA,
   input  logic [BIT_WISE-1:0] ALUB,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BIT_WISE-1:0] valE,
   output logic [3:0]          CC
);

   localparam int MSB = BIT_WISE - 1;

   state_t state, state_next;

   logic                  accept;
   logic                  is_mul;
   logic                  mul_start;
   logic                  mul_done;
   logic [2*BIT_WISE-1:0] mul_product;
   logic                  mul_set_cc;
   logic                  load_done;

   logic [SHW-1:0]        shamt;
   logic [BIT_WISE:0]     wide;
   logic [BIT_WISE-1:0]   sc_res;
   logic                  sc_cf;
   logic                  sc_of;

   logic [BIT_WISE-1:0]   fin_res;
   logic                  fin_cf;
   logic                  fin_of;
   logic                  fin_set_cc;
   logic [3:0]            cc_new;

   assign accept    = in_valid && in_ready;
   assign is_mul    = (ALUfun == ALU_MUL);
   assign mul_start = accept && is_mul;
   assign shamt     = ALUA[SHW-1:0];

   alu_mul_iter #(
      .BIT_WISE (BIT_WISE)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (ALUA),
      .b       (ALUB),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle datapath, evaluated on the live inputs in the accept cycle.
   // The extra bit of 'wide' carries the carry/borrow or the bit shifted out.
   always_comb begin
      wide   = '0;
      sc_res = '0;
      sc_cf  = 1'b0;
      sc_of  = 1'b0;
      case (ALUfun)
         ALU_ADD: begin
            wide   = {1'b0, ALUB} + {1'b0, ALUA};
            sc_res = wide[BIT_WISE-1:0];
            sc_cf  = wide[BIT_WISE];
            sc_of  = (ALUA[MSB] == ALUB[MSB]) && (sc_res[MSB] != ALUB[MSB]);
         end
         ALU_SUB: begin
            wide   = {1'b0, ALUB} - {1'b0, ALUA};
            sc_res = wide[BIT_WISE-1:0];
            sc_cf  = wide[BIT_WISE];
            sc_of  = (ALUA[MSB] != ALUB[MSB]) && (sc_res[MSB] != ALUB[MSB]);
         end
         ALU_AND: sc_res = ALUB & ALUA;
         ALU_OR:  sc_res = ALUB | ALUA;
         ALU_XOR: sc_res = ALUB ^ ALUA;
         ALU_SHL: begin
            wide   = {1'b0, ALUB} << shamt;
            sc_res = wide[BIT_WISE-1:0];
            sc_cf  = wide[BIT_WISE];
         end
         // Right shifts use a guard bit below the LSB; it ends up holding
         // the last bit shifted out, or 0 for a zero shift.
         ALU_SHR: begin
            wide   = {ALUB, 1'b0} >> shamt;
            sc_res = wide[BIT_WISE:1];
            sc_cf  = wide[0];
         end
         ALU_SAR: begin
            wide   = $signed({ALUB, 1'b0}) >>> shamt;
            sc_res = wide[BIT_WISE:1];
            sc_cf  = wide[0];
         end
         default: begin
            wide   = '0;
            sc_res = '0;
         end
      endcase
   end

   // Result and flags that get written on DONE entry.
   always_comb begin
      if (state == ST_MUL) begin
         fin_res    = mul_product[BIT_WISE-1:0];
         fin_cf     = |mul_product[2*BIT_WISE-1:BIT_WISE];
         fin_of     = fin_cf;
         fin_set_cc = mul_set_cc;
      end else begin
         fin_res    = sc_res;
         fin_cf     = sc_cf;
         fin_of     = sc_of;
         fin_set_cc = set_cc;
      end
      cc_new        = '0;
      cc_new[CC_ZF] = (fin_res == '0);
      cc_new[CC_SF] = fin_res[MSB];
      cc_new[CC_OF] = fin_of;
      cc_new[CC_CF] = fin_cf;
   end

   assign load_done = (accept && !is_mul) || ((state == ST_MUL) && mul_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = is_mul ? ST_MUL : ST_DONE;
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  state_next = is_mul ? ST_MUL : ST_DONE;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valE       <= '0;
         CC         <= CC_RESET;
         mul_set_cc <= 1'b0;
      end else begin
         if (mul_start) begin
            mul_set_cc <= set_cc;
         end
         if (load_done) begin
            valE <= fin_res;
            if (fin_set_cc) begin
               CC <= cc_new;
            end
         end
      end
   end

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq (BIT_WISE=64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  ALUfun;
   logic        set_cc;
   logic [63:0] ALUA;
   logic [63:0] ALUB;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] valE;
   logic [3:0]  CC;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_seq #(.BIT_WISE(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ALUfun    (ALUfun),
      .set_cc    (set_cc),
      .ALUA      (ALUA),
      .ALUB      (ALUB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .valE      (valE),
      .CC        (CC)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one op while the ALU is idle; returns one cycle after the accept.
   task automatic issue(input logic [3:0] fn, input logic [63:0] b,
                        input logic [63:0] a, input logic sc);
      in_valid = 1'b1;
      ALUfun   = fn;
      ALUB     = b;
      ALUA     = a;
      set_cc   = sc;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++; if (CC !== 4'b0001) begin failures++; $display("FAIL reset_cc: got %b want 0001", CC); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (valE !== 64'h0) begin failures++; $display("FAIL reset_valE: got %h want 0", valE); end
      step();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add();
      issue(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_ovf_valid: got %b want 1", out_valid); end
      checks++; if (valE !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL add_ovf_val: got %h want 8000000000000000", valE); end
      checks++; if (CC !== 4'b0110) begin failures++; $display("FAIL add_ovf_cc: got %b want 0110", CC); end
      drain();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain_valid: got %b want 0", out_valid); end
      // Unsigned carry out, no signed overflow.
      issue(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
      checks++; if (valE !== 64'h0) begin failures++; $display("FAIL add_carry_val: got %h want 0", valE); end
      checks++; if (CC !== 4'b1001) begin failures++; $display("FAIL add_carry_cc: got %b want 1001", CC); end
      drain();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      issue(4'd1, 64'h3, 64'h5, 1'b1);
      // Offer XOR immediately; it must wait behind the stalled SUB result.
      in_valid = 1'b1;
      ALUfun   = 4'd4;
      ALUB     = 64'hF0;
      ALUA     = 64'hF0;
      set_cc   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_hold_valid[%0d]: got %b want 1", i, out_valid); end
         checks++; if (valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL b2b_hold_val[%0d]: got %h want fffffffffffffffe", i, valE); end
         checks++; if (CC !== 4'b1010) begin failures++; $display("FAIL b2b_hold_cc[%0d]: got %b want 1010", i, CC); end
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready[%0d]: got %b want 0", i, in_ready); end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_on_out_ready: got %b want 1", in_ready); end
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_xor_valid: got %b want 1", out_valid); end
      checks++; if (valE !== 64'h0) begin failures++; $display("FAIL b2b_xor_val: got %h want 0", valE); end
      checks++; if (CC !== 4'b0001) begin failures++; $display("FAIL b2b_xor_cc: got %b want 0001", CC); end
      drain();
   endtask

   task automatic test_set_cc_gating();
      issue(4'd3, 64'h8000_0000_0000_0000, 64'h0, 1'b1);
      checks++; if (CC !== 4'b0010) begin failures++; $display("FAIL or_cc: got %b want 0010", CC); end
      drain();
      issue(4'd2, 64'h0, 64'h0, 1'b0);
      checks++; if (valE !== 64'h0) begin failures++; $display("FAIL gate_val: got %h want 0", valE); end
      checks++; if (CC !== 4'b0010) begin failures++; $display("FAIL gate_cc: got %b want 0010", CC); end
      drain();
   endtask

   task automatic test_shifts();
      issue(4'd5, 64'h8000_0000_0000_0001, 64'h1, 1'b1);
      checks++; if (valE !== 64'h2) begin failures++; $display("FAIL shl_val: got %h want 2", valE); end
      checks++; if (CC !== 4'b1000) begin failures++; $display("FAIL shl_cc: got %b want 1000", CC); end
      drain();
      issue(4'd7, 64'h8000_0000_0000_0000, 64'h43, 1'b1);
      checks++; if (valE !== 64'hF000_0000_0000_0000) begin failures++; $display("FAIL sar_val: got %h want f000000000000000", valE); end
      checks++; if (CC !== 4'b0010) begin failures++; $display("FAIL sar_cc: got %b want 0010", CC); end
      drain();
      issue(4'd6, 64'h10, 64'h5, 1'b1);
      checks++; if (valE !== 64'h0) begin failures++; $display("FAIL shr_val: got %h want 0", valE); end
      checks++; if (CC !== 4'b1001) begin failures++; $display("FAIL shr_cc: got %b want 1001", CC); end
      drain();
      // Amount field is A[5:0]; 0x40 means a zero shift, so CF must be 0.
      issue(4'd5, 64'h8000_0000_0000_0000, 64'h40, 1'b1);
      checks++; if (valE !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL shl0_val: got %h want 8000000000000000", valE); end
      checks++; if (CC !== 4'b0010) begin failures++; $display("FAIL shl0_cc: got %b want 0010", CC); end
      drain();
      issue(4'd9, 64'h5, 64'h3, 1'b1);
      checks++; if (valE !== 64'h0) begin failures++; $display("FAIL undef_val: got %h want 0", valE); end
      checks++; if (CC !== 4'b0001) begin failures++; $display("FAIL undef_cc: got %b want 0001", CC); end
      drain();
   endtask

   task automatic test_mul();
      int cyc;
      issue(4'd8, 64'h1_0000_0000, 64'h1_0000_0000, 1'b1);
      cyc = 1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mul_early_valid: got %b want 0", out_valid); end
      while (out_valid !== 1'b1 && cyc < 200) begin
         step();
         cyc++;
      end
      checks++; if (cyc !== 65) begin failures++; $display("FAIL mul_latency: got %0d want 65", cyc); end
      checks++; if (valE !== 64'h0) begin failures++; $display("FAIL mul_val: got %h want 0", valE); end
      checks++; if (CC !== 4'b1101) begin failures++; $display("FAIL mul_cc: got %b want 1101", CC); end
      drain();
      issue(4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 1'b1);
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 200) begin
         step();
         cyc++;
      end
      checks++; if (cyc !== 65) begin failures++; $display("FAIL mul2_latency: got %0d want 65", cyc); end
      checks++; if (valE !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL mul2_val: got %h want fffffffffffffffd", valE); end
      checks++; if (CC !== 4'b1110) begin failures++; $display("FAIL mul2_cc: got %b want 1110", CC); end
      drain();
   endtask

   task automatic test_mul_reset();
      logic seen;
      issue(4'd8, 64'h1_0000_0000, 64'h1_0000_0000, 1'b1);
      for (int i = 1; i < 20; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (CC !== 4'b0001) begin failures++; $display("FAIL mulrst_cc: got %b want 0001", CC); end
      checks++; if (valE !== 64'h0) begin failures++; $display("FAIL mulrst_val: got %h want 0", valE); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mulrst_in_ready: got %b want 1", in_ready); end
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (out_valid !== 1'b0) seen = 1'b1;
         step();
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mulrst_no_valid: got %b want 0", seen); end
      checks++; if (CC !== 4'b0001) begin failures++; $display("FAIL mulrst_cc_after: got %b want 0001", CC); end
      issue(4'd0, 64'h2, 64'h3, 1'b1);
      checks++; if (valE !== 64'h5) begin failures++; $display("FAIL mulrst_next_val: got %h want 5", valE); end
      checks++; if (CC !== 4'b0000) begin failures++; $display("FAIL mulrst_next_cc: got %b want 0000", CC); end
      drain();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      ALUfun    = 4'd0;
      set_cc    = 1'b0;
      ALUA      = '0;
      ALUB      = '0;
      out_ready = 1'b0;
      #1;
      test_reset();
      test_add();
      test_back_to_back();
      test_set_cc_gating();
      test_shifts();
      test_mul();
      test_mul_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alu_seq
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor of the Y86 execute-stage ALU. It adds XOR, shifts, and an iterative unsigned multiply, and owns a registered condition-code (CC) register. The operand convention is valB op valA: SUB computes ALUB − ALUA, and shifts shift ALUB by ALUA. It sits in the execute stage between decode operand latches and the memory/writeback stage.

Parameters:
BIT_WISE, 64, operand/result width; legal values are powers of two ≥ 8.
SHW, $clog2(BIT_WISE), shift-amount width (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  ALU can accept an operation this cycle
ALUfun  in  4  operation code (see package)
set_cc  in  1  update CC when this operation completes
ALUA  in  BIT_WISE  operand A
ALUB  in  BIT_WISE  operand B
out_valid  out  1  valE holds a completed result
out_ready  in  1  consumer accepts the result
valE  out  BIT_WISE  result (registered)
CC  out  4  condition codes {CF,OF,SF,ZF}, bits 3..0 (registered)

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, valE=0, out_valid=0, CC=4'b0001 (ZF=1, others 0). in_ready is 1 in the cycle after reset.
- Accept rule: an operation is captured when in_valid && in_ready. ALUfun, ALUA, ALUB and set_cc are latched at capture; later input changes are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back throughput of 1 op/cycle for single-cycle ops.
- States:
  - IDLE → DONE on accepting a single-cycle op.
  - IDLE → MUL on accepting MUL.
  - MUL → DONE after BIT_WISE iterations.
  - DONE → IDLE on out_ready with no new accept.
  - DONE → DONE/MUL on out_ready with a simultaneous accept.
- Latency: single-cycle ops have out_valid=1 in the cycle after the accept. MUL has out_valid=1 exactly BIT_WISE+1 cycles after the accept.
- out_valid and valE stay stable while out_ready=0, with no loss and no overwrite.
- Ops, wrapping modulo 2^BIT_WISE:
  - ADD=0: B+A
  - SUB=1: B−A
  - AND=2: B&A
  - OR=3: B|A
  - XOR=4: B^A
  - SHL=5: B<<A[SHW-1:0]
  - SHR=6: logical B>>A[SHW-1:0]
  - SAR=7: arithmetic B>>>A[SHW-1:0]
  - MUL=8: low half of unsigned B*A
  - Codes 9–15: result 0, CC updated as a logic op.
- MUL datapath: shift-add, one multiplier bit per cycle, LSB first. Uses a 2*BIT_WISE accumulator, kept internally for the flags.
- Flags, computed on the final result R:
  - ZF: R==0.
  - SF: R[MSB].
  - OF:
    - ADD: A[MSB]==B[MSB] && R[MSB]!=B[MSB].
    - SUB: A[MSB]!=B[MSB] && R[MSB]!=B[MSB].
    - MUL: same value as CF.
    - All others: 0.
  - CF:
    - ADD: carry out.
    - SUB: borrow (B<A unsigned).
    - Shifts: last bit shifted out, 0 when the shift amount is 0.
    - MUL: upper half of the product nonzero.
    - Logic ops: 0.
- CC is written in the same cycle valE is written (DONE entry), only if the latched set_cc=1. Otherwise CC holds.
- Reset during MUL or DONE: the operation is discarded, all state returns to reset values, and CC is not updated.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is not captured.

Decomposition:
- Package alu_pkg holds:
  - the ALUfun localparams (ADD..MUL)
  - CC bit indices ZF=0, SF=1, OF=2, CF=3
  - the CC reset constant 4'b0001.
- Sub-module alu_mul_iter: iterative shift-add multiplier. Ports: start, a, b, done, product[2*BIT_WISE-1:0].
- Single-cycle ops and flag logic stay in alu_seq.

Test Plan:
- Reset check: hold rst 2 cycles → CC=4'b0001, out_valid=0, valE=0, in_ready=1 the next cycle.
- Signed-overflow ADD: ADD with ALUB=0x7FFF_FFFF_FFFF_FFFF, ALUA=1, set_cc=1 → one cycle later valE=0x8000_0000_0000_0000, CC={CF0,OF1,SF1,ZF0}.
- Back-to-back with backpressure: SUB B=3, A=5, then XOR B=A=0xF0, out_ready held 0 for 3 cycles → valE=0xFFFF_FFFF_FFFF_FFFE stays stable; CC shows CF=1, SF=1; in_ready=0 until out_ready. Then XOR result 0 with ZF=1.
- set_cc gating: AND B=0, A=0 with set_cc=0 → valE=0 and CC unchanged from the prior value.
- Shifts: SHL B=0x8000_0000_0000_0001, A=1 → valE=0x2, CF=1. SAR B=0x8000_0000_0000_0000, A=0x43 (amount 3) → valE=0xF000_0000_0000_0000, CF=0.
- MUL and reset mid-op: MUL B=0x1_0000_0000, A=0x1_0000_0000 → out_valid exactly 65 cycles after the accept, valE=0, ZF=1, CF=1, OF=1. Repeat with rst asserted in cycle 20 → no out_valid, CC=4'b0001.
